// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage SRAM-like to AXI3 responder:
// FSM states, SRAM-side size codes, fixed AXI field values, strobe/size mapping.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AWW,
      B,
      DONE
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] LEN_SINGLE = 4'd0;

   // Size code 3 is not a legal SRAM request and is served as a full word.
   function automatic logic [3:0] size_addr_to_wstrb(input logic [1:0] size,
                                                     input logic [1:0] addr_lo);
      logic [3:0] byte_mask;
      logic [3:0] half_mask;
      byte_mask = 4'b0001;
      half_mask = 4'b0011;
      case (size)
         SZ_BYTE: return byte_mask << addr_lo;
         SZ_HALF: return half_mask << addr_lo;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
      return (size == 2'd3) ? {1'b0, SZ_WORD} : {1'b0, size};
   endfunction

endpackage

// File: rtl/sram_axi_responder.sv
// SRAM-like request to single-beat AXI3 read/write bridge, one request in flight.
// Optional SRAM_AXI_WR_POST_EN: writes complete at AW/W handshake, B is tracked by b_pending.
module sram_axi_responder
   import mem_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clk,
   input  logic        aresetn,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,

   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,

   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,

   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   state_e      state_q, state_d;
   logic        req_wr_q;
   logic [1:0]  req_size_q;
   logic [31:0] req_addr_q;
   logic [31:0] req_wdata_q;
   logic [31:0] rdata_q;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        idle_ready;
   logic        accept;
   logic        aw_fire;
   logic        w_fire;

`ifdef SRAM_AXI_WR_POST_EN
   logic        b_pending_q, b_pending_d;
`endif

   // Responses are single-beat with a fixed ID; error codes are not reported upstream.
   logic unused_resp;
   assign unused_resp = ^{rid, rresp, bid, bresp};

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      idle_ready   = 1'b0;
      accept       = 1'b0;
      aw_fire      = 1'b0;
      w_fire       = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      data_data_ok = 1'b0;
`ifdef SRAM_AXI_WR_POST_EN
      b_pending_d  = b_pending_q & ~bvalid;
      bready       = b_pending_q;
`else
      bready       = 1'b0;
`endif

      case (state_q)
         IDLE: begin
`ifdef SRAM_AXI_WR_POST_EN
            // Hold off new requests until the posted write's B arrives.
            idle_ready = ~b_pending_q | bvalid;
`else
            idle_ready = 1'b1;
`endif
            accept = data_req & idle_ready;
            if (accept) begin
               state_d = data_wr ? AWW : AR;
            end
         end

         AR: begin
            arvalid = 1'b1;
            if (arready) begin
               state_d = R;
            end
         end

         R: begin
            rready = 1'b1;
            if (rvalid && rlast) begin
               state_d = DONE;
            end
         end

         AWW: begin
            awvalid = ~aw_done_q;
            wvalid  = ~w_done_q;
            aw_fire = ~aw_done_q & awready;
            w_fire  = ~w_done_q & wready;
            if (aw_fire) aw_done_d = 1'b1;
            if (w_fire)  w_done_d  = 1'b1;
            // AW and W may finish in either order or together.
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
`ifdef SRAM_AXI_WR_POST_EN
               b_pending_d = 1'b1;
               state_d     = DONE;
`else
               state_d     = B;
`endif
            end
         end

         B: begin
            bready = 1'b1;
            if (bvalid) begin
               state_d = DONE;
            end
         end

         DONE: begin
            data_data_ok = 1'b1;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         req_wr_q    <= 1'b0;
         req_size_q  <= 2'd0;
         req_addr_q  <= 32'd0;
         req_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         if (accept) begin
            req_wr_q    <= data_wr;
            req_size_q  <= data_size;
            req_addr_q  <= data_addr;
            req_wdata_q <= data_wdata;
         end
         if (state_q == R && rvalid && rlast) begin
            rdata_q <= rdata;
         end
      end
   end

`ifdef SRAM_AXI_WR_POST_EN
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         b_pending_q <= 1'b0;
      end else begin
         b_pending_q <= b_pending_d;
      end
   end
`endif

   // Gated by reset so a request held during reset is never reported as taken.
   assign data_addr_ok = accept & aresetn;
   assign data_rdata   = rdata_q;

   assign arid    = AXI_ID;
   assign araddr  = req_addr_q;
   assign arlen   = LEN_SINGLE;
   assign arsize  = size_to_axsize(req_size_q);
   assign arburst = BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   assign awid    = AXI_ID;
   assign awaddr  = req_addr_q;
   assign awlen   = LEN_SINGLE;
   assign awsize  = size_to_axsize(req_size_q);
   assign awburst = BURST_INCR;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;

   assign wid     = AXI_ID;
   assign wdata   = req_wdata_q;
   assign wstrb   = req_wr_q ? size_addr_to_wstrb(req_size_q, req_addr_q[1:0]) : 4'b0000;
   assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_responder.sv
// Bench for sram_axi_responder: table of SRAM requests against a delay-configurable
// AXI slave model, scoreboard of expected results checked on each data_ok pulse.
module tb_sram_axi_responder;

   localparam logic [3:0] AXI_ID = 4'd1;
`ifdef SRAM_AXI_WR_POST_EN
   localparam int WR_LAT  = 2;
   localparam int AWD_LAT = 5;
`else
   localparam int WR_LAT  = 3;
   localparam int AWD_LAT = 6;
`endif
   localparam logic [31:0] AX_CONST_EXP = {13'd0, AXI_ID, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0};
   localparam logic [31:0] W_CONST_EXP  = {27'd0, AXI_ID, 1'b1};

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        data_req = 1'b0, data_wr = 1'b0;
   logic [1:0]  data_size = 2'd0;
   logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
   logic [31:0] data_rdata;
   logic        data_addr_ok, data_data_ok;
   logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
   logic [31:0] araddr, awaddr, wdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock;
   logic        arvalid, rready, awvalid, wvalid, wlast, bready;
   logic        arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, awready = 1'b0;
   logic        wready = 1'b0, bvalid = 1'b0;
   logic [3:0]  rid = 4'd0, bid = 4'd0;
   logic [31:0] rdata = 32'd0;
   logic [1:0]  rresp = 2'd0, bresp = 2'd0;

   sram_axi_responder dut (
      .clk(clk), .aresetn(aresetn),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdval;
      logic [2:0]  xsize;
      logic [3:0]  wstrb;
      int          lat;
   } vec_t;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rv,
                               input logic [2:0] xs, input logic [3:0] ws, input int lat);
      vec_t v;
      v.wr = wr; v.size = size; v.addr = addr; v.wdata = wd; v.rdval = rv;
      v.xsize = xs; v.wstrb = ws; v.lat = lat;
      return v;
   endfunction

   // ---------------- AXI slave model (updates 1 time unit after each rising edge)
   int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] rd_value = 32'd0;
   bit r_pend = 0, aw_got = 0, w_got = 0;
   bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic [31:0] cap_araddr, cap_awaddr, cap_wdata, cap_ar_const, cap_aw_const, cap_w_const;
   logic [2:0]  cap_arsize, cap_awsize;
   logic [3:0]  cap_wstrb;

   always @(posedge clk) begin
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (ar_hs) begin
         cap_araddr   = araddr;
         cap_arsize   = arsize;
         cap_ar_const = {13'd0, arid, arlen, arburst, arlock, arcache, arprot};
      end
      if (aw_hs) begin
         cap_awaddr   = awaddr;
         cap_awsize   = awsize;
         cap_aw_const = {13'd0, awid, awlen, awburst, awlock, awcache, awprot};
      end
      if (w_hs) begin
         cap_wdata   = wdata;
         cap_wstrb   = wstrb;
         cap_w_const = {27'd0, wid, wlast};
      end
      #1;
      if (!aresetn) begin
         arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         r_pend = 0; aw_got = 0; w_got = 0;
      end else begin
         if (ar_hs) begin arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
         if (arvalid && !arready) begin
            if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
         end
         if (r_hs) begin rvalid = 0; rlast = 0; r_pend = 0; end
         if (r_pend && !rvalid) begin
            if (r_cnt >= r_delay) begin
               rvalid = 1; rlast = 1; rdata = rd_value; rid = AXI_ID; rresp = 2'b10;
            end else r_cnt++;
         end
         if (aw_hs) begin awready = 0; aw_cnt = 0; aw_got = 1; end
         if (awvalid && !awready) begin
            if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
         end
         if (w_hs) begin wready = 0; w_cnt = 0; w_got = 1; end
         if (wvalid && !wready) begin
            if (w_cnt >= w_delay) wready = 1; else w_cnt++;
         end
         if (b_hs) bvalid = 0;
         if (aw_got && w_got && !bvalid) begin
            if (b_cnt >= b_delay) begin
               bvalid = 1; bid = AXI_ID; bresp = 2'b00; aw_got = 0; w_got = 0; b_cnt = 0;
            end else b_cnt++;
         end
      end
   end

   // ---------------- Monitor and scoreboard (samples on the falling edge)
   vec_t sb[$];
   vec_t cur_exp;
   vec_t e;
   int cyc = 0, acc_cnt = 0, done_cnt = 0, acc_cyc = 0, acc_gap = 0;
   int b_hs_cnt = 0, b_cyc = 0, awv_cyc = 0, wv_cyc = 0, b_overlap = 0;
   logic [31:0] last_rd = 32'd0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (aresetn) begin
         if (awvalid) awv_cyc++;
         if (wvalid) wv_cyc++;
         if (bready && (awvalid || wvalid)) b_overlap++;
         if (bvalid && bready) begin b_hs_cnt++; b_cyc = cyc; end
         if (data_data_ok) begin
            if (data_req) check("addr_ok_in_done", {31'd0, data_addr_ok}, 32'd0);
            check("sb_nonempty_at_data_ok", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("latency", cyc - acc_cyc, e.lat);
               if (!e.wr) begin
                  check("rdata", data_rdata, e.rdval);
                  check("araddr", cap_araddr, e.addr);
                  check("arsize", {29'd0, cap_arsize}, {29'd0, e.xsize});
                  check("ar_const", cap_ar_const, AX_CONST_EXP);
                  last_rd = e.rdval;
               end else begin
                  check("rdata_hold", data_rdata, last_rd);
                  check("awaddr", cap_awaddr, e.addr);
                  check("awsize", {29'd0, cap_awsize}, {29'd0, e.xsize});
                  check("wstrb", {28'd0, cap_wstrb}, {28'd0, e.wstrb});
                  check("wdata", cap_wdata, e.wdata);
                  check("aw_const", cap_aw_const, AX_CONST_EXP);
                  check("w_const", cap_w_const, W_CONST_EXP);
               end
            end
            done_cnt++;
         end
         if (data_addr_ok) begin
            check("one_outstanding", sb.size(), 32'd0);
            sb.push_back(cur_exp);
            acc_gap = cyc - acc_cyc;
            acc_cyc = cyc;
            acc_cnt++;
         end
      end
   end

   // ---------------- Stimulus
   task automatic run_req(input vec_t v);
      int acc0, done0, n;
      acc0 = acc_cnt;
      done0 = done_cnt;
      cur_exp = v;
      rd_value = v.rdval;
      @(posedge clk); #1;
      data_req = 1; data_wr = v.wr; data_size = v.size; data_addr = v.addr; data_wdata = v.wdata;
      n = 0;
      while (acc_cnt == acc0 && n < 64) begin @(posedge clk); n++; end
      #1 data_req = 0;
      check("accepted", acc_cnt - acc0, 32'd1);
      n = 0;
      while (done_cnt == done0 && n < 64) begin @(posedge clk); n++; end
      check("completed", done_cnt - done0, 32'd1);
   endtask

   vec_t vecs[10];
   int d0, a0, awv0, wv0, ov0, b0, n;

   initial begin
      vecs[0] = mk(0, 2'd2, 32'hBFD0_F000, 32'h0,         32'h1234_5678, 3'd2, 4'h0, 3);
      vecs[1] = mk(1, 2'd0, 32'hBFD0_0003, 32'hAB00_0000, 32'h0,         3'd0, 4'h8, WR_LAT);
      vecs[2] = mk(1, 2'd1, 32'hBFD0_0002, 32'h5A5A_0000, 32'h0,         3'd1, 4'hC, WR_LAT);
      vecs[3] = mk(0, 2'd0, 32'h0000_1001, 32'h0,         32'hCAFE_F00D, 3'd0, 4'h0, 3);
      vecs[4] = mk(1, 2'd0, 32'h0000_0001, 32'h0000_EE00, 32'h0,         3'd0, 4'h2, WR_LAT);
      vecs[5] = mk(1, 2'd3, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         3'd2, 4'hF, WR_LAT);
      vecs[6] = mk(1, 2'd1, 32'h0000_0001, 32'h00FF_FF00, 32'h0,         3'd1, 4'h6, WR_LAT);
      vecs[7] = mk(0, 2'd1, 32'h0000_0022, 32'h0,         32'h89AB_CDEF, 3'd1, 4'h0, 3);
      vecs[8] = mk(1, 2'd1, 32'h0000_0003, 32'h1200_0000, 32'h0,         3'd1, 4'h8, WR_LAT);
      vecs[9] = mk(1, 2'd2, 32'h0000_2000, 32'h0102_0304, 32'h0,         3'd2, 4'hF, WR_LAT);

      repeat (2) @(posedge clk); #1;
      check("reset_outs", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, 32'd0);
      check("reset_rdata", data_rdata, 32'd0);
      #2 aresetn = 1;

      for (int i = 0; i < 10; i++) run_req(vecs[i]);

      // AW accepted 3 cycles late, W immediately.
      aw_delay = 3; awv0 = awv_cyc; wv0 = wv_cyc; ov0 = b_overlap; d0 = done_cnt;
      run_req(mk(1, 2'd2, 32'h0000_3000, 32'h600D_F00D, 32'h0, 3'd2, 4'hF, AWD_LAT));
      repeat (3) @(posedge clk);
      check("aw_valid_cycles", awv_cyc - awv0, 32'd4);
      check("w_valid_cycles", wv_cyc - wv0, 32'd1);
      check("bready_before_aw_done", b_overlap - ov0, 32'd0);
      check("single_data_ok", done_cnt - d0, 32'd1);
      aw_delay = 0;

      // Back-to-back reads with data_req held high.
      d0 = done_cnt; a0 = acc_cnt;
      cur_exp = mk(0, 2'd2, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 3'd2, 4'h0, 3);
      rd_value = cur_exp.rdval;
      @(posedge clk); #1;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_4000;
      n = 0;
      while (done_cnt - d0 < 2 && n < 80) begin @(posedge clk); n++; end
      #1 data_req = 0;
      check("b2b_accepts", acc_cnt - a0, 32'd2);
      check("b2b_done", done_cnt - d0, 32'd2);
      check("b2b_gap", acc_gap, 32'd4);

      // Reset while the read response is still outstanding.
      r_delay = 20;
      a0 = acc_cnt;
      cur_exp = mk(0, 2'd2, 32'h0000_5000, 32'h0, 32'h7777_7777, 3'd2, 4'h0, 3);
      rd_value = cur_exp.rdval;
      @(posedge clk); #1;
      data_req = 1; data_addr = 32'h0000_5000;
      n = 0;
      while (acc_cnt == a0 && n < 64) begin @(posedge clk); n++; end
      #1 data_req = 0;
      repeat (3) @(posedge clk);
      #3 check("in_r_rready", {31'd0, rready}, 32'd1);
      aresetn = 0;
      #1;
      check("midrst_outs", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, 32'd0);
      check("midrst_rdata", data_rdata, 32'd0);
      sb.delete();
      last_rd = 32'd0;
      repeat (2) @(posedge clk);
      #3 aresetn = 1;
      r_delay = 0;
      d0 = done_cnt;
      run_req(mk(0, 2'd2, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 3'd2, 4'h0, 3));
      repeat (3) @(posedge clk);
      check("post_reset_single_ok", done_cnt - d0, 32'd1);

`ifdef SRAM_AXI_WR_POST_EN
      // Posted write, B delayed: the following read waits for bvalid.
      b_delay = 5; b0 = b_hs_cnt;
      run_req(mk(1, 2'd2, 32'h0000_7000, 32'hA5A5_A5A5, 32'h0, 3'd2, 4'hF, 2));
      check("post_ok_before_b", b_hs_cnt - b0, 32'd0);
      run_req(mk(0, 2'd2, 32'h0000_7000, 32'h0, 32'hA5A5_A5A5, 3'd2, 4'h0, 3));
      check("post_b_seen", b_hs_cnt - b0, 32'd1);
      check("post_accept_at_b", acc_cyc, b_cyc);
      b_delay = 0;
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_axi_responder.md
Name: sram_axi_responder

Overview:
- Responder end of the SRAM-like data interface (req/wr/size/addr/wdata -> addr_ok/data_ok/rdata) driven by the MEM-stage uncached path.
- Converts each accepted request into one single-beat AXI3 read (AR/R) or write (AW/W/B) transaction on the data AXI port.
- One outstanding request at a time.
- Sits between the MEM stage's uncached initiator and the top-level AXI crossbar.

Parameters:
- AXI_ID, 4'd1, value driven on arid/awid/wid.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- data_req  in  1  request valid
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word
- data_addr  in  32  byte address
- data_wdata  in  32  write data, already lane-aligned
- data_rdata  out  32  read data; valid while data_data_ok = 1
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  one-cycle completion pulse
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/4/3/2/2/4/3/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/4/3/2/2/4/3/1  AXI write address
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
- wready  in  1
- bid/bresp/bvalid  in  4/2/1  AXI write response
- bready  out  1

Behaviour:
- Reset (async, aresetn = 0): state = IDLE; all valid/ready/ok outputs 0; data_rdata = 0; latched request = 0. Reset mid-transaction drops valids immediately; no completion pulse is produced.
- FSM states: IDLE, AR, R, AWW, B, DONE.
- IDLE:
  - data_addr_ok = data_req, combinational.
  - On data_req, latch wr/size/addr/wdata.
  - Next state: AWW if wr = 1, else AR.
- AR: arvalid = 1 until arready; then R.
- R:
  - rready = 1.
  - On rvalid & rlast, latch rdata into data_rdata; go to DONE.
  - rresp is ignored.
- AWW:
  - awvalid and wvalid both asserted.
  - Per-channel done flags drop each valid independently after its handshake.
  - Go to B when both are done; this covers same-cycle or either-order completion.
- B: bready = 1; on bvalid go to DONE.
- DONE: data_data_ok = 1 for exactly one cycle; next state IDLE. data_addr_ok is 0 in DONE.
- Constant AXI fields:
  - arlen = awlen = 0; arburst = awburst = 2'b01; lock/cache/prot = 0; wlast = 1.
  - ids = AXI_ID.
  - arsize = awsize = {1'b0, size}, with size 3 mapped to 2.
  - Addresses pass through unmodified.
- wstrb, derived from size and addr[1:0]:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]; addr[0] = 1 is the initiator's error, and the strobe is masked to 4 bits.
  - word: 4'b1111
- Latency with a zero-wait slave:
  - Read: req cycle T, arvalid T+1, rvalid at T+2, data_ok at T+3.
  - Write: awvalid/wvalid T+1, bvalid T+2, data_ok T+3.
- data_rdata holds its last value until the next read completes.
- data_req held high during DONE is not accepted until IDLE.

Optional Feature:
- Macro: SRAM_AXI_WR_POST_EN.
- Defined:
  - AWW goes directly to DONE once both handshakes complete, so write data_ok arrives one cycle earlier.
  - A b_pending flag is set at the same time; bready = b_pending, and the flag clears on bvalid.
  - IDLE asserts data_addr_ok only when b_pending = 0 (or bvalid arrives this cycle). This preserves write-then-read ordering.
- Undefined: write completion waits for B, as described above; b_pending does not exist.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, AR, R, AWW, B, DONE)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - AXI constants BURST_INCR = 2'b01, LEN_SINGLE = 4'd0
  - function size_addr_to_wstrb(size, addr[1:0])
- Sub-module: none required. The wstrb generator is the package function, and the FSM stays in one module.

Test Plan:
- Read word 0xBFD0_F000 with a zero-wait slave returning 0x1234_5678:
  - addr_ok cycle 0; araddr = 0xBFD0_F000, arsize = 2 at cycle 1; data_ok pulse at cycle 3.
  - data_rdata = 0x1234_5678, held afterwards.
- Byte write, addr 0xBFD0_0003, wdata 0xAB00_0000: awsize = 0, wstrb = 4'b1000, wdata unchanged; data_ok one cycle after bvalid.
- Write with awready delayed 3 cycles and wready immediate: wvalid drops after 1 cycle, awvalid held 4 cycles, B entered only after AW completes, a single data_ok.
- Back-to-back requests with data_req held high: second addr_ok appears only in the IDLE after the DONE cycle; never two outstanding.
- aresetn pulled low while in R with rvalid pending: all outputs are 0 immediately; after release, a new read completes normally with no spurious data_ok.
- SRAM_AXI_WR_POST_EN defined, write followed by a read, bvalid delayed 5 cycles:
  - Write data_ok precedes B.
  - Read addr_ok is withheld until bvalid; arvalid only after that.
